single_port_ram_core: RTL and testbench
=======================================

Name: single_port_ram_core

Overview:
- Synchronous single-port RAM: one address bus shared by reads and writes, registered read data with a one-cycle valid strobe.
- Sits behind the interfaceX bundle in the memory subsystem; the bench drives stimulus and samples responses through that interface.
- Contents are cleared by reset, so every location reads back as a known value.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- ADDR_WIDTH, 4, address width.
- DEPTH, 16, number of words; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears memory and outputs.
- wr_en  input  1  write request for the current cycle.
- rd_en  input  1  read request for the current cycle.
- addr  input  ADDR_WIDTH  word address for both reads and writes.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  high for exactly the cycle in which data_out holds fresh read data.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named rst.
- Reset, while rst=1 regardless of clk:
  - all DEPTH words = 0
  - data_out = 0
  - valid_out = 0
- Reset mid-operation aborts any pending read: valid_out drops immediately, with no glitch to 1.
- Write: on a rising edge with wr_en=1 and rd_en=0, mem[addr] <= data_in.
  - data_out holds its previous value; valid_out <= 0.
- Read: on a rising edge with rd_en=1 and wr_en=0, data_out <= mem[addr] and valid_out <= 1.
  - Read latency is 1 cycle: data is visible after the edge that sampled the request.
- Idle (wr_en=0, rd_en=0): valid_out <= 0; data_out holds.
- Simultaneous wr_en=1 and rd_en=1: write has priority.
  - mem[addr] <= data_in; the read is ignored.
  - valid_out <= 0; data_out holds.
- Read of a location written on the previous edge returns the new data (no stale read).
- Back-to-back reads on consecutive cycles: valid_out stays high, data_out updates every cycle.
- Address is always in range because DEPTH = 2**ADDR_WIDTH; there is no wrap or out-of-range handling.
- No internal state machine; behaviour is purely per-cycle as described above.
- Memory is an array of registers so that reset clears it; no inferred-RAM dependence.

Optional Feature:
- Macro: RAM_PARITY_EN.
- When defined:
  - each word stores one extra even-parity bit, computed from data_in on write.
  - on read, parity is recomputed over the stored data and compared with the stored bit.
  - an additional output, parity_err (1 bit), is registered alongside data_out and is high only in cycles where valid_out=1 and the parity check fails.
  - reset clears parity_err and all stored parity bits.
- When not defined: no parity storage and no parity_err port; behaviour is otherwise identical.

Test Plan:
- Reset check: assert rst for one cycle, then read addresses 0..15 -> each read gives valid_out=1 one cycle later and data_out=0.
- Write then read: write 0xDEADBEEF to addr 3, read addr 3 on the next cycle -> data_out=0xDEADBEEF with valid_out=1 one cycle after the read request.
- Full sweep: write addr*0x11111111 to all 16 addresses, then read them back in order -> each value matches, and valid_out stays continuously high during the back-to-back reads.
- Collision: with addr 5 holding 0x1, drive wr_en=1, rd_en=1, addr=5, data_in=0xA5A5A5A5 -> valid_out=0 and data_out unchanged; a following read of addr 5 returns 0xA5A5A5A5.
- Async reset mid-read: issue a read of addr 3 (holding 0xDEADBEEF) and raise rst between clock edges -> data_out=0 and valid_out=0 immediately; a later read of addr 3 returns 0.
- With RAM_PARITY_EN: write 0x00000007 to addr 2, force-flip the stored parity bit, then read addr 2 -> parity_err=1 together with valid_out=1; an unflipped read gives parity_err=0.

Source files
------------

// File: rtl/single_port_ram_core.sv
// Single-port register-file RAM with registered read data and a one-cycle valid strobe.
// Defining RAM_PARITY_EN adds a stored even-parity bit per word and a registered parity_err output.
module single_port_ram_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
`ifdef RAM_PARITY_EN
    output logic                  parity_err,
`endif
    output logic                  valid_out
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;

    // A write wins over a simultaneous read; the read is dropped and data_out holds.
    always_comb begin
        mem_d       = mem_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        if (wr_en) begin
            mem_d[addr] = data_in;
        end else if (rd_en) begin
            data_out_d  = mem_q[addr];
            valid_out_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q       <= '{default: '0};
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

`ifdef RAM_PARITY_EN
    logic [DEPTH-1:0] par_q, par_d;
    logic             parity_err_q, parity_err_d;

    // Stored bit makes each word plus parity have even weight; a mismatch flags corruption.
    always_comb begin
        par_d        = par_q;
        parity_err_d = 1'b0;
        if (wr_en) begin
            par_d[addr] = ^data_in;
        end else if (rd_en) begin
            parity_err_d = (^mem_q[addr]) != par_q[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q        <= '0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_single_port_ram_core.sv
// Self-checking bench for single_port_ram_core: a reference memory model pushes expected read
// data into a queue as reads are issued, and each task pops and compares once the DUT responds.
module tb_single_port_ram_core;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        valid_out;
`ifdef RAM_PARITY_EN
    logic        parity_err;
`endif

    int          checks;
    int          fails;
    logic [31:0] mem_model [16];
    logic [31:0] exp_data;
    logic        exp_valid;
    logic [31:0] exp_q [$];

    single_port_ram_core #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(4),
        .DEPTH     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
`ifdef RAM_PARITY_EN
        .parity_err(parity_err),
`endif
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem_model[i] = '0;
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_q.delete();
    endtask

    // Drives one request cycle, updates the reference model, then waits until just after the edge.
    task automatic drive(input logic wr, input logic rd, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en   = wr;
        rd_en   = rd;
        addr    = a;
        data_in = d;
        if (wr) begin
            mem_model[a] = d;
            exp_valid    = 1'b0;
        end else if (rd) begin
            exp_q.push_back(mem_model[a]);
            exp_data  = mem_model[a];
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_data_out: actual=%h required=%h", data_out, 32'h0);
        end
        checks++;
        if (valid_out !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_valid_out: actual=%b required=0", valid_out);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'(i), 32'h0);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
            checks++;
            if (valid_out !== 1'b1) begin
                fails++;
                $display("[TB] FAIL reset_read_valid[%0d]: actual=%b required=1", i, valid_out);
            end
            checks++;
            if (data_out !== exp) begin
                fails++;
                $display("[TB] FAIL reset_read_data[%0d]: actual=%h required=%h", i, data_out, exp);
            end
        end
        drive(1'b0, 1'b0, 4'd0, 32'h0);
        checks++;
        if (valid_out !== 1'b0) begin
            fails++;
            $display("[TB] FAIL idle_valid: actual=%b required=0", valid_out);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] exp;
        drive(1'b1, 1'b0, 4'd3, 32'hDEADBEEF);
        checks++;
        if (valid_out !== 1'b0 || data_out !== exp_data) begin
            fails++;
            $display("[TB] FAIL write_hold: actual=%b/%h required=0/%h", valid_out, data_out, exp_data);
        end
        drive(1'b0, 1'b1, 4'd3, 32'h0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        checks++;
        if (valid_out !== 1'b1 || data_out !== exp) begin
            fails++;
            $display("[TB] FAIL write_then_read: actual=%b/%h required=1/%h", valid_out, data_out, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 4'(i), 32'(i) * 32'h11111111);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'(i), 32'h0);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
            checks++;
            if (valid_out !== 1'b1) begin
                fails++;
                $display("[TB] FAIL sweep_valid[%0d]: actual=%b required=1", i, valid_out);
            end
            checks++;
            if (data_out !== exp) begin
                fails++;
                $display("[TB] FAIL sweep_data[%0d]: actual=%h required=%h", i, data_out, exp);
            end
        end
        drive(1'b0, 1'b0, 4'd0, 32'h0);
    endtask

    task automatic test_collision();
        logic [31:0] exp;
        drive(1'b1, 1'b0, 4'd5, 32'h00000001);
        drive(1'b0, 1'b1, 4'd5, 32'h0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        checks++;
        if (data_out !== exp) begin
            fails++;
            $display("[TB] FAIL collision_preread: actual=%h required=%h", data_out, exp);
        end
        drive(1'b1, 1'b1, 4'd5, 32'hA5A5A5A5);
        checks++;
        if (valid_out !== 1'b0) begin
            fails++;
            $display("[TB] FAIL collision_valid: actual=%b required=0", valid_out);
        end
        checks++;
        if (data_out !== exp_data) begin
            fails++;
            $display("[TB] FAIL collision_hold: actual=%h required=%h", data_out, exp_data);
        end
        drive(1'b0, 1'b1, 4'd5, 32'h0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        checks++;
        if (valid_out !== 1'b1 || data_out !== exp) begin
            fails++;
            $display("[TB] FAIL collision_readback: actual=%b/%h required=1/%h", valid_out, data_out, exp);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] exp;
        drive(1'b1, 1'b0, 4'd3, 32'hDEADBEEF);
        drive(1'b0, 1'b1, 4'd3, 32'h0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        checks++;
        if (valid_out !== 1'b1 || data_out !== exp) begin
            fails++;
            $display("[TB] FAIL pre_reset_read: actual=%b/%h required=1/%h", valid_out, data_out, exp);
        end
        // Second read is pending when reset arrives between edges.
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b1;
        addr  = 4'd3;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 32'h0) begin
            fails++;
            $display("[TB] FAIL async_reset_immediate: actual=%b/%h required=0/%h", valid_out, data_out, 32'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0 || data_out !== 32'h0) begin
            fails++;
            $display("[TB] FAIL async_reset_held: actual=%b/%h required=0/%h", valid_out, data_out, 32'h0);
        end
        @(negedge clk);
        rst   = 1'b0;
        rd_en = 1'b0;
        drive(1'b0, 1'b1, 4'd3, 32'h0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        checks++;
        if (valid_out !== 1'b1 || data_out !== exp) begin
            fails++;
            $display("[TB] FAIL post_reset_read: actual=%b/%h required=1/%h", valid_out, data_out, exp);
        end
    endtask

`ifdef RAM_PARITY_EN
    task automatic test_parity();
        drive(1'b1, 1'b0, 4'd2, 32'h00000007);
        drive(1'b0, 1'b1, 4'd2, 32'h0);
        void'(exp_q.pop_front());
        checks++;
        if (valid_out !== 1'b1 || parity_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL parity_clean: actual=%b/%b required=1/0", valid_out, parity_err);
        end
        @(negedge clk);
        dut.par_q[2] = ~dut.par_q[2];
        drive(1'b0, 1'b1, 4'd2, 32'h0);
        void'(exp_q.pop_front());
        checks++;
        if (valid_out !== 1'b1 || parity_err !== 1'b1) begin
            fails++;
            $display("[TB] FAIL parity_flipped: actual=%b/%b required=1/1", valid_out, parity_err);
        end
        drive(1'b0, 1'b0, 4'd0, 32'h0);
        checks++;
        if (parity_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL parity_idle: actual=%b required=0", parity_err);
        end
    endtask
`endif

    initial begin
        checks  = 0;
        fails   = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        addr    = '0;
        data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_collision();
        test_async_reset();
`ifdef RAM_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
